// File: rtl/led_mode_clkgen_if.sv
// Board-side bundle for the blink-rate controller:
// switch/direction inputs and divided clock, strobe, mode and LED outputs.
interface led_mode_clkgen_if #(
    parameter int unsigned LED_W = 16
);
    logic [1:0]       SW;
    logic             DIR;
    logic             mode_clock;
    logic             tick;
    logic [1:0]       mode;
    logic [LED_W-1:0] LD;

    modport master (
        output SW, DIR,
        input  mode_clock, tick, mode, LD
    );

    modport slave (
        input  SW, DIR,
        output mode_clock, tick, mode, LD
    );
endinterface

// File: rtl/led_mode_clkgen.sv
// Switch-selected clock divider with glitch-free rate changes
// and a rotating LED pattern advanced on each mode_clock rising toggle.
module led_mode_clkgen #(
    parameter int unsigned     CNT_W    = 24,
    parameter int unsigned     LED_W    = 16,
    parameter int unsigned     DIV1     = 1000,
    parameter int unsigned     DIV2     = 500,
    parameter int unsigned     DIV3     = 200,
    parameter logic [LED_W-1:0] LED_INIT = LED_W'(1)
) (
    input logic           SCLK,
    input logic           RST,
    led_mode_clkgen_if.slave bus
);

    if (DIV1 < 2 || (DIV1 >> CNT_W) != 0) begin : g_div1_bad
        $error("DIV1 out of range for CNT_W");
    end
    if (DIV2 < 2 || (DIV2 >> CNT_W) != 0) begin : g_div2_bad
        $error("DIV2 out of range for CNT_W");
    end
    if (DIV3 < 2 || (DIV3 >> CNT_W) != 0) begin : g_div3_bad
        $error("DIV3 out of range for CNT_W");
    end
    if (LED_W < 2) begin : g_led_bad
        $error("LED_W must be at least 2");
    end

    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(DIV1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(DIV2);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(DIV3);

    typedef enum logic {
        ST_STOP,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sw_q1, sw_s;
    logic             dir_q1, dir_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] term;
    logic [1:0]       mode_q, mode_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [LED_W-1:0] ld_q, ld_d;
    logic             last;

    always_comb begin
        case (mode_q)
            2'd2:    term = TERM2;
            2'd3:    term = TERM3;
            default: term = TERM1;
        endcase
    end

    assign last = (cnt_q == term - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        ld_d    = ld_q;
        unique case (state_q)
            ST_STOP: begin
                mode_d = 2'd0;
                cnt_d  = '0;
                clk_d  = 1'b0;
                ld_d   = '0;
                if (sw_s != 2'd0) begin
                    state_d = ST_RUN;
                    mode_d  = sw_s;
                    ld_d    = LED_INIT;
                end
            end
            ST_RUN: begin
                if (sw_s == 2'd0) begin
                    state_d = ST_STOP;
                    mode_d  = 2'd0;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    ld_d    = '0;
                end else if (last) begin
                    // sw_s is the latest request; loading it here
                    // defers any rate change to a half-period edge
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = 1'b1;
                    mode_d = sw_s;
                    if (!clk_q) begin
                        ld_d = dir_s ? {ld_q[0], ld_q[LED_W-1:1]}
                                     : {ld_q[LED_W-2:0], ld_q[LED_W-1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            sw_q1   <= 2'd0;
            sw_s    <= 2'd0;
            dir_q1  <= 1'b0;
            dir_s   <= 1'b0;
            state_q <= ST_STOP;
            mode_q  <= 2'd0;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            ld_q    <= '0;
        end else begin
            sw_q1   <= bus.SW;
            sw_s    <= sw_q1;
            dir_q1  <= bus.DIR;
            dir_s   <= dir_q1;
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            ld_q    <= ld_d;
        end
    end

    assign bus.mode_clock = clk_q;
    assign bus.tick       = tick_q;
    assign bus.mode       = mode_q;
    assign bus.LD         = ld_q;

endmodule

// File: tb/tb_led_mode_clkgen.sv
// Directed bench for led_mode_clkgen with small dividers (10/5/3):
// reset, steady rotation, direction, rate switch, stop and mid-run reset.
module tb_led_mode_clkgen;

    localparam int LED_W = 16;

    logic SCLK = 1'b0;
    logic RST;

    led_mode_clkgen_if #(.LED_W(LED_W)) bus ();

    led_mode_clkgen #(
        .CNT_W   (8),
        .LED_W   (LED_W),
        .DIV1    (10),
        .DIV2    (5),
        .DIV3    (3),
        .LED_INIT(16'h0001)
    ) dut (
        .SCLK(SCLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 SCLK = ~SCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  sw;
        logic        dir;
        int          n;
        logic        mc;
        logic        tk;
        logic [1:0]  md;
        logic [15:0] ld;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] obs();
        return {12'd0, bus.mode_clock, bus.tick, bus.mode, bus.LD};
    endfunction

    function automatic logic [31:0] ex(logic mc, logic tk,
                                       logic [1:0] md, logic [15:0] ld);
        return {12'd0, mc, tk, md, ld};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge SCLK);
        #1;
    endtask

    // run one 20-cycle period ending on a rising toggle
    task automatic period(string name, logic [1:0] md, logic [15:0] ld);
        int tk;
        tk = 0;
        for (int c = 0; c < 19; c++) begin
            step();
            tk += int'(bus.tick);
        end
        chk({name, "_half_ticks"}, 32'(tk), 32'd1);
        step();
        chk(name, obs(), ex(1'b1, 1'b1, md, ld));
    endtask

    initial begin
        RST     = 1'b1;
        bus.SW  = 2'd1;
        bus.DIR = 1'b0;

        tbl[0] = '{1'b1, 2'd1, 1'b0, 3,  1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[1] = '{1'b0, 2'd1, 1'b0, 2,  1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[2] = '{1'b0, 2'd1, 1'b0, 10, 1'b0, 1'b0, 2'd1, 16'h0001};
        tbl[3] = '{1'b0, 2'd1, 1'b0, 1,  1'b1, 1'b1, 2'd1, 16'h0002};
        tbl[4] = '{1'b0, 2'd1, 1'b0, 9,  1'b1, 1'b0, 2'd1, 16'h0002};
        tbl[5] = '{1'b0, 2'd1, 1'b0, 1,  1'b0, 1'b1, 2'd1, 16'h0002};
        tbl[6] = '{1'b0, 2'd1, 1'b0, 9,  1'b0, 1'b0, 2'd1, 16'h0002};
        tbl[7] = '{1'b0, 2'd1, 1'b0, 1,  1'b1, 1'b1, 2'd1, 16'h0004};

        for (int i = 0; i < 8; i++) begin
            RST     = tbl[i].rst;
            bus.SW  = tbl[i].sw;
            bus.DIR = tbl[i].dir;
            for (int c = 0; c < tbl[i].n; c++) begin
                step();
                chk($sformatf("vec%0d_c%0d", i, c), obs(),
                    ex(tbl[i].mc, tbl[i].tk, tbl[i].md, tbl[i].ld));
            end
        end

        for (int i = 3; i <= 16; i++) begin
            period($sformatf("rotl%0d", i), 2'd1, 16'(32'd1 << (i % 16)));
        end

        bus.DIR = 1'b1;
        period("rotr_8000", 2'd1, 16'h8000);
        period("rotr_4000", 2'd1, 16'h4000);
        bus.DIR = 1'b0;

        // rate switch requested with counter at 4
        repeat (4) step();
        bus.SW = 2'd3;
        for (int c = 5; c < 10; c++) begin
            step();
            chk($sformatf("sw_old_c%0d", c), obs(),
                ex(1'b1, 1'b0, 2'd1, 16'h4000));
        end
        step();
        chk("sw_boundary", obs(), ex(1'b0, 1'b1, 2'd3, 16'h4000));
        repeat (2) begin
            step();
            chk("sw_new_lo", obs(), ex(1'b0, 1'b0, 2'd3, 16'h4000));
        end
        step();
        chk("sw_new_rise", obs(), ex(1'b1, 1'b1, 2'd3, 16'h8000));
        repeat (2) begin
            step();
            chk("sw_new_hi", obs(), ex(1'b1, 1'b0, 2'd3, 16'h8000));
        end
        step();
        chk("sw_new_fall", obs(), ex(1'b0, 1'b1, 2'd3, 16'h8000));

        // stop lands on the same edge as a rising terminal event
        bus.SW = 2'd0;
        repeat (2) begin
            step();
            chk("stop_sync", obs(), ex(1'b0, 1'b0, 2'd3, 16'h8000));
        end
        step();
        chk("stop_applied", obs(), ex(1'b0, 1'b0, 2'd0, 16'h0000));
        repeat (6) begin
            step();
            chk("stop_idle", obs(), ex(1'b0, 1'b0, 2'd0, 16'h0000));
        end

        bus.SW = 2'd2;
        repeat (2) begin
            step();
            chk("m2_sync", obs(), ex(1'b0, 1'b0, 2'd0, 16'h0000));
        end
        repeat (5) begin
            step();
            chk("m2_enter", obs(), ex(1'b0, 1'b0, 2'd2, 16'h0001));
        end
        step();
        chk("m2_first", obs(), ex(1'b1, 1'b1, 2'd2, 16'h0002));

        bus.SW = 2'd3;
        repeat (4) step();
        chk("m3_pend", obs(), ex(1'b1, 1'b0, 2'd2, 16'h0002));
        step();
        chk("m3_apply", obs(), ex(1'b0, 1'b1, 2'd3, 16'h0002));
        bus.SW = 2'd2;
        repeat (2) begin
            step();
            chk("m2_pend", obs(), ex(1'b0, 1'b0, 2'd3, 16'h0002));
        end

        RST    = 1'b1;
        bus.SW = 2'd1;
        step();
        chk("mid_rst", obs(), ex(1'b0, 1'b0, 2'd0, 16'h0000));
        RST = 1'b0;
        repeat (2) begin
            step();
            chk("post_rst_sync", obs(), ex(1'b0, 1'b0, 2'd0, 16'h0000));
        end
        repeat (10) begin
            step();
            chk("post_rst_m1", obs(), ex(1'b0, 1'b0, 2'd1, 16'h0001));
        end
        step();
        chk("post_rst_first", obs(), ex(1'b1, 1'b1, 2'd1, 16'h0002));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
